// File: rtl/bus_responder_if.sv
// Bus bundle between an initiator and the bus_responder memory target.
interface bus_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic [1:0]  size;
  logic [1:0]  prot;
  logic [1:0]  trans;
  logic [31:0] rdata;
  logic        abort;
  logic        stall;

  modport master (
    output addr, wdata, write, size, prot, trans,
    input  rdata, abort, stall
  );

  modport slave (
    input  addr, wdata, write, size, prot, trans,
    output rdata, abort, stall
  );
endinterface

// File: rtl/bus_responder.sv
// Wait-state memory responder with byte-lane writes and abort reporting.
// Optional privilege checking below PROT_LIMIT is enabled by BUS_RESPONDER_PROT_EN.
module bus_responder #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned NSEQ_WAIT   = 2,
  parameter int unsigned SEQ_WAIT    = 0,
  parameter logic [31:0] PROT_LIMIT  = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           reset,
  bus_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        stall_q, stall_n;
  logic        abort_q, abort_n;
  logic [31:0] rdata_q, rdata_n;

  logic [31:0] l_addr, l_wdata;
  logic        l_write;
  logic [1:0]  l_size;

  logic [31:0] r_addr, r_wdata;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_priv;

  logic        accept, complete, err, mem_we;
  logic [3:0]  n_wait;
  logic [3:0]  be;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef BUS_RESPONDER_PROT_EN
  logic l_priv;
`else
  logic unused_prot;
  assign unused_prot = ^{bus.prot, PROT_LIMIT};
`endif

  assign bus.rdata = rdata_q;
  assign bus.abort = abort_q;
  assign bus.stall = stall_q;

  // While waiting, the bus is ignored and the latched request drives completion.
  always_comb begin
    accept  = (state != WAIT) && bus.trans[1];
    n_wait  = bus.trans[0] ? 4'(SEQ_WAIT) : 4'(NSEQ_WAIT);
    r_addr  = (state == WAIT) ? l_addr  : bus.addr;
    r_wdata = (state == WAIT) ? l_wdata : bus.wdata;
    r_write = (state == WAIT) ? l_write : bus.write;
    r_size  = (state == WAIT) ? l_size  : bus.size;
`ifdef BUS_RESPONDER_PROT_EN
    r_priv  = (state == WAIT) ? l_priv  : bus.prot[1];
`else
    r_priv  = 1'b1;
`endif
    idx      = r_addr[AW+1:2];
    complete = ((state == WAIT) && (cnt == 4'd0)) || (accept && (n_wait == 4'd0));

    err = 1'b0;
    if ({2'b00, r_addr[31:2]} >= DEPTH_WORDS) err = 1'b1;
    if (r_size == 2'b11) err = 1'b1;
    if ((r_size == 2'b01) && r_addr[0]) err = 1'b1;
    if ((r_size == 2'b10) && (r_addr[1:0] != 2'b00)) err = 1'b1;
`ifdef BUS_RESPONDER_PROT_EN
    if (!r_priv && (r_addr < PROT_LIMIT)) err = 1'b1;
`else
    if (!r_priv) err = 1'b1;
`endif

    case (r_size)
      2'b00:   be = 4'b0001 << r_addr[1:0];
      2'b01:   be = r_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall_n = stall_q;
    abort_n = 1'b0;
    rdata_n = rdata_q;
    mem_we  = 1'b0;

    case (state)
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = DONE;
          stall_n = 1'b0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        if (accept) begin
          if (n_wait == 4'd0) begin
            state_n = DONE;
          end else begin
            state_n = WAIT;
            stall_n = 1'b1;
            cnt_n   = n_wait - 4'd1;
          end
        end else begin
          state_n = IDLE;
        end
      end
    endcase

    if (complete) begin
      abort_n = err;
      if (!err) begin
        if (r_write) mem_we  = 1'b1;
        else         rdata_n = mem[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_q <= 1'b0;
      abort_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      stall_q <= stall_n;
      abort_q <= abort_n;
      rdata_q <= rdata_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_addr  <= bus.addr;
      l_wdata <= bus.wdata;
      l_write <= bus.write;
      l_size  <= bus.size;
`ifdef BUS_RESPONDER_PROT_EN
      l_priv  <= bus.prot[1];
`endif
    end
  end

  // Memory has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder (default and NSEQ_WAIT=3 instances).
module tb_bus_responder;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [1:0] P_PRIV = 2'b10;
`ifdef BUS_RESPONDER_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  bus_responder_if bus ();
  bus_responder_if bus3 ();

  bus_responder dut (.clk(clk), .reset(reset), .bus(bus));
  bus_responder #(.NSEQ_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic put(input bit sel, input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic [1:0] s, input logic [1:0] p,
                     input logic [1:0] t);
    if (sel) begin
      bus3.addr = a; bus3.wdata = d; bus3.write = w;
      bus3.size = s; bus3.prot = p;  bus3.trans = t;
    end else begin
      bus.addr = a;  bus.wdata = d;  bus.write = w;
      bus.size = s;  bus.prot = p;   bus.trans = t;
    end
  endtask

  // One transfer followed by one idle edge; reports completion outputs and wait count.
  task automatic do_xfer(input bit sel, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [1:0] s, input logic [1:0] p,
                         input logic [1:0] t, output logic ab, output logic ab_next,
                         output int waits, output logic [31:0] rd);
    @(negedge clk);
    put(sel, a, d, w, s, p, t);
    @(posedge clk); #1;
    waits = 0;
    while (((sel ? bus3.stall : bus.stall) === 1'b1) && (waits < 20)) begin
      @(posedge clk); #1;
      waits++;
    end
    ab = sel ? bus3.abort : bus.abort;
    rd = sel ? bus3.rdata : bus.rdata;
    @(negedge clk);
    put(sel, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
    @(posedge clk); #1;
    ab_next = sel ? bus3.abort : bus.abort;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", bus.rdata); else passed++;
    checks++; if (bus.abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", bus.abort); else passed++;
    checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else passed++;
    checks++; if (bus3.stall !== 1'b0) $display("FAIL reset_stall3: got %b want 0", bus3.stall); else passed++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wait_latch();
    @(negedge clk);
    put(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'b10, P_PRIV, T_NSEQ);
    @(posedge clk); #1;
    checks++; if (bus.stall !== 1'b1) $display("FAIL wl_accept_stall: got %b want 1", bus.stall); else passed++;
    @(negedge clk);
    put(0, 32'h10, 32'hBAD0BAD0, 1'b1, 2'b10, P_PRIV, T_NSEQ);
    @(posedge clk); #1;
    checks++; if (bus.stall !== 1'b1) $display("FAIL wl_wait_stall: got %b want 1", bus.stall); else passed++;
    checks++; if (bus.abort !== 1'b0) $display("FAIL wl_wait_abort: got %b want 0", bus.abort); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.stall !== 1'b0) $display("FAIL wl_done_stall: got %b want 0", bus.stall); else passed++;
    checks++; if (bus.abort !== 1'b0) $display("FAIL wl_done_abort: got %b want 0", bus.abort); else passed++;
    @(negedge clk);
    put(0, 32'h10, '0, 1'b0, 2'b10, P_PRIV, T_SEQ);
    @(posedge clk); #1;
    checks++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL wl_read: got %h want deadbeef", bus.rdata); else passed++;
    checks++; if (bus.stall !== 1'b0) $display("FAIL wl_read_stall: got %b want 0", bus.stall); else passed++;
    @(negedge clk);
    put(0, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
  endtask

  task automatic test_byte_lanes();
    logic ab, abn; int w; logic [31:0] rd;
    do_xfer(0, 32'h20, 32'h11223344, 1'b1, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    do_xfer(0, 32'h22, 32'h00AA0000, 1'b1, 2'b00, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b0) $display("FAIL bl_byte_abort: got %b want 0", ab); else passed++;
    do_xfer(0, 32'h20, '0, 1'b0, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (rd !== 32'h11AA3344) $display("FAIL bl_byte_read: got %h want 11aa3344", rd); else passed++;
    do_xfer(0, 32'h23, '0, 1'b0, 2'b00, P_PRIV, T_NSEQ, ab, abn, w, rd);
    checks++; if (w !== 2) $display("FAIL bl_nseq_waits: got %0d want 2", w); else passed++;
    checks++; if (rd !== 32'h11AA3344) $display("FAIL bl_byte_size_read: got %h want 11aa3344", rd); else passed++;
    do_xfer(0, 32'h24, 32'h55667788, 1'b1, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    do_xfer(0, 32'h26, 32'hCAFE0000, 1'b1, 2'b01, P_PRIV, T_SEQ, ab, abn, w, rd);
    do_xfer(0, 32'h24, '0, 1'b0, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (rd !== 32'hCAFE7788) $display("FAIL bl_half_read: got %h want cafe7788", rd); else passed++;
  endtask

  task automatic test_abort();
    logic ab, abn; int w; logic [31:0] rd;
    do_xfer(0, 32'h30, 32'hA5A5A5A5, 1'b1, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    do_xfer(0, 32'h30, '0, 1'b0, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL ab_setup_read: got %h want a5a5a5a5", rd); else passed++;
    do_xfer(0, 32'h31, 32'h12345678, 1'b1, 2'b01, P_PRIV, T_NSEQ, ab, abn, w, rd);
    checks++; if (w !== 2) $display("FAIL ab_mis_waits: got %0d want 2", w); else passed++;
    checks++; if (ab !== 1'b1) $display("FAIL ab_mis_abort: got %b want 1", ab); else passed++;
    checks++; if (abn !== 1'b0) $display("FAIL ab_mis_pulse: got %b want 0", abn); else passed++;
    checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL ab_mis_rdata: got %h want a5a5a5a5", rd); else passed++;
    do_xfer(0, 32'h0000_8000, '0, 1'b0, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b1) $display("FAIL ab_range_abort: got %b want 1", ab); else passed++;
    checks++; if (abn !== 1'b0) $display("FAIL ab_range_pulse: got %b want 0", abn); else passed++;
    checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL ab_range_rdata: got %h want a5a5a5a5", rd); else passed++;
    do_xfer(0, 32'h30, '0, 1'b0, 2'b11, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b1) $display("FAIL ab_size3_abort: got %b want 1", ab); else passed++;
    do_xfer(0, 32'h32, 32'h0, 1'b1, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b1) $display("FAIL ab_word_mis_abort: got %b want 1", ab); else passed++;
    do_xfer(0, 32'h30, '0, 1'b0, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b0) $display("FAIL ab_after_abort: got %b want 0", ab); else passed++;
    checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL ab_mem_kept: got %h want a5a5a5a5", rd); else passed++;
  endtask

  task automatic test_reset_in_wait();
    logic ab, abn; int w; logic [31:0] rd;
    do_xfer(1, 32'h40, 32'h0BADF00D, 1'b1, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b0) $display("FAIL rw_setup_abort: got %b want 0", ab); else passed++;
    @(negedge clk);
    put(1, 32'h40, 32'hFFFFFFFF, 1'b1, 2'b10, P_PRIV, T_NSEQ);
    @(posedge clk); #1;
    checks++; if (bus3.stall !== 1'b1) $display("FAIL rw_accept_stall: got %b want 1", bus3.stall); else passed++;
    @(negedge clk);
    put(1, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
    @(posedge clk); #1;
    checks++; if (bus3.stall !== 1'b1) $display("FAIL rw_wait_stall: got %b want 1", bus3.stall); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if (bus3.stall !== 1'b0) $display("FAIL rw_reset_stall: got %b want 0", bus3.stall); else passed++;
    checks++; if (bus3.rdata !== 32'h0) $display("FAIL rw_reset_rdata: got %h want 00000000", bus3.rdata); else passed++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    put(1, 32'h40, '0, 1'b0, 2'b10, P_PRIV, T_SEQ);
    @(posedge clk); #1;
    checks++; if (bus3.rdata !== 32'h0BADF00D) $display("FAIL rw_old_value: got %h want 0badf00d", bus3.rdata); else passed++;
    checks++; if (bus3.stall !== 1'b0) $display("FAIL rw_read_stall: got %b want 0", bus3.stall); else passed++;
    @(negedge clk);
    put(1, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
  endtask

  task automatic test_prot();
    logic ab, abn; int w; logic [31:0] rd;
    do_xfer(0, 32'h100, 32'h11111111, 1'b1, 2'b10, 2'b10, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b0) $display("FAIL pr_priv_setup: got %b want 0", ab); else passed++;
    do_xfer(0, 32'h100, 32'h22222222, 1'b1, 2'b10, 2'b00, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== PROT_ON) $display("FAIL pr_user_abort: got %b want %b", ab, PROT_ON); else passed++;
    do_xfer(0, 32'h100, '0, 1'b0, 2'b10, 2'b10, T_SEQ, ab, abn, w, rd);
    checks++;
    if (rd !== (PROT_ON ? 32'h11111111 : 32'h22222222))
      $display("FAIL pr_user_effect: got %h want %h", rd, PROT_ON ? 32'h11111111 : 32'h22222222);
    else passed++;
    do_xfer(0, 32'h100, 32'h600D600D, 1'b1, 2'b10, 2'b10, T_SEQ, ab, abn, w, rd);
    checks++; if (ab !== 1'b0) $display("FAIL pr_priv_abort: got %b want 0", ab); else passed++;
    do_xfer(0, 32'h100, '0, 1'b0, 2'b10, 2'b10, T_SEQ, ab, abn, w, rd);
    checks++; if (rd !== 32'h600D600D) $display("FAIL pr_priv_read: got %h want 600d600d", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic ab, abn; int w; logic [31:0] rd;
    logic [31:0] vals [4];
    vals = '{32'h01020304, 32'hA0B0C0D0, 32'h13579BDF, 32'hFEDCBA98};
    for (int i = 0; i < 4; i++)
      do_xfer(0, 32'(4 * i), vals[i], 1'b1, 2'b10, P_PRIV, T_SEQ, ab, abn, w, rd);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      put(0, 32'(4 * i), '0, 1'b0, 2'b10, P_PRIV, T_SEQ);
      @(posedge clk); #1;
      checks++; if (bus.rdata !== vals[i]) $display("FAIL b2b_read%0d: got %h want %h", i, bus.rdata, vals[i]); else passed++;
      checks++; if (bus.stall !== 1'b0) $display("FAIL b2b_stall%0d: got %b want 0", i, bus.stall); else passed++;
    end
    @(negedge clk);
    put(0, 32'h50, 32'h5A5A0F0F, 1'b1, 2'b10, P_PRIV, T_SEQ);
    @(posedge clk); #1;
    @(negedge clk);
    put(0, 32'h50, '0, 1'b0, 2'b10, P_PRIV, T_SEQ);
    @(posedge clk); #1;
    checks++; if (bus.rdata !== 32'h5A5A0F0F) $display("FAIL b2b_wr_rd: got %h want 5a5a0f0f", bus.rdata); else passed++;
    @(negedge clk);
    put(0, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
  endtask

  initial begin
    reset = 1'b0;
    put(0, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
    put(1, '0, '0, 1'b0, 2'b00, 2'b00, T_IDLE);
    test_reset();
    test_wait_latch();
    test_byte_lanes();
    test_abort();
    test_reset_in_wait();
    test_prot();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 8192: memory size in 32-bit words.
REQ-002 Parameter NSEQ_WAIT, default 2: wait cycles for a non-sequential transfer, range 0-15.
REQ-003 Parameter SEQ_WAIT, default 0: wait cycles for a sequential transfer, range 0-15.
REQ-004 Parameter PROT_LIMIT, default 32'h0000_1000: byte addresses below this value are privileged-only.
REQ-005 Ports: clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 Ports: reset  in  1  asynchronous, active-high reset.
REQ-007 Ports: addr  in  32  byte address.
REQ-008 Ports: wdata  in  32  write data, little-endian byte lanes.
REQ-009 Ports: write  in  1  write when 1, read when 0.
REQ-010 Ports: size  in  2  transfer size: 00 byte, 01 halfword, 10 word; 11 is reserved.
REQ-011 Ports: prot  in  2  protection: bit1 privileged, bit0 data/opcode.
REQ-012 Ports: trans  in  2  transfer type: 00 IDLE, 01 COUPLED, 10 NSEQ, 11 SEQ.
REQ-013 Ports: rdata  out  32  registered read data.
REQ-014 Ports: abort  out  1  registered; one-cycle pulse on a failed transfer.
REQ-015 Ports: stall  out  1  registered; while 1, the initiator holds the bus.

Function
REQ-016 The block SHALL use states IDLE, WAIT and DONE.
REQ-017 Accept: in IDLE or DONE, a rising edge with trans equal to 10 or 11 SHALL accept the request and latch addr, wdata, write, size and prot.
REQ-018 Non-accept: trans equal to 00 or 01 SHALL NOT start an access, and the state SHALL return to IDLE.
REQ-019 Wait count: the latched wait count SHALL be N = NSEQ_WAIT for NSEQ and N = SEQ_WAIT for SEQ.
REQ-020 Zero wait: if N = 0, the access SHALL complete on the accepting edge, the state SHALL go to DONE, and stall SHALL stay 0.
REQ-021 Nonzero wait: if N > 0, stall SHALL go to 1 on the accepting edge, the state SHALL go to WAIT, and the counter SHALL load N-1.
REQ-022 In WAIT, each edge SHALL decrement the counter; on the edge where the counter is 0, the access SHALL complete, stall SHALL go to 0, and the state SHALL go to DONE.
REQ-023 While stall = 1, all bus inputs SHALL be ignored, and the latched request SHALL be used.
REQ-024 Read completion: rdata SHALL take the word at index addr[31:2], for every size.
REQ-025 Write completion: only the byte lanes selected by size and addr[1:0] SHALL be written, using the same wdata lanes; all other bytes SHALL be preserved.
REQ-026 Abort conditions: addr[31:2] >= DEPTH_WORDS; misalignment (halfword with addr[0]=1, or word with addr[1:0] not 00); size = 11.
REQ-027 On abort, the completion edge SHALL drive abort to 1 for exactly one cycle.
REQ-028 On abort, memory SHALL NOT be written and rdata SHALL hold its previous value.
REQ-029 On abort, the wait count SHALL still be honoured.
REQ-030 abort SHALL be 0 on every edge that is not an aborting completion.
REQ-031 Back-to-back: a new request SHALL be acceptable on the edge immediately after a completion (DONE to accept), with no bubble.
REQ-032 A read immediately following a write to the same word SHALL return the newly written data.

Reset
REQ-033 On reset, the outputs SHALL be rdata = 0, abort = 0 and stall = 0, the state SHALL be IDLE, and the counter SHALL be 0, regardless of clk.
REQ-034 Reset asserted during WAIT SHALL discard the pending access; no memory write SHALL occur.
REQ-035 Memory contents SHALL NOT be affected by reset.
REQ-036 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-037 Macro BUS_RESPONDER_PROT_EN: when defined, an access with prot[1] = 0 to an address below PROT_LIMIT SHALL abort per REQ-027 to REQ-029.
REQ-038 When BUS_RESPONDER_PROT_EN is undefined, prot SHALL be ignored, and no protection logic SHALL be built.

Verification
REQ-039 Reset, then NSEQ word write of 32'hDEADBEEF at 0x10 with defaults, then SEQ read of 0x10 -> stall high for 2 cycles on the write; the read returns 32'hDEADBEEF one edge after accept with stall = 0.
REQ-040 Word 0x20 = 32'h11223344, then a byte write of 8'hAA at 0x22 (wdata = 32'h00AA0000), then a read -> 32'h11AA3344.
REQ-041 Halfword write at 0x31, and separately a read of byte address 4*DEPTH_WORDS -> abort pulses one cycle at completion; memory and rdata are unchanged.
REQ-042 NSEQ_WAIT = 3 write, with reset asserted 1 cycle after accept -> stall = 0 immediately; a later read of the same address returns the old value.
REQ-043 With BUS_RESPONDER_PROT_EN defined: a prot = 00 write to 0x100 -> abort = 1; a prot = 10 write to 0x100 -> success. With the macro undefined, both writes succeed.
REQ-044 Four back-to-back SEQ reads of 0x0, 0x4, 0x8 and 0xC with SEQ_WAIT = 0 -> four consecutive rdata values with stall = 0 throughout.
